// File: rtl/rect_loop_pkg.sv
// Shared types and index helper for the rectangle loop engine.
package rect_loop_pkg;

  typedef enum logic {
    CORNERS   = 1'b0,
    PERIMETER = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Flat bit position of matrix element (r,c); row 0 / column 0 sits at the MSB.
  function automatic int bit_idx(input int r, input int c, input int rows, input int cols);
    return rows * cols - 1 - (r * cols + c);
  endfunction

endpackage

// File: rtl/rect_row_mask.sv
// Combinational XOR mask for one matrix row of a rectangle.
// Endpoint rows get the full column span, interior rows only the two edge columns.
// ends_only forces the edge-column pattern, which is how the corner path reuses it.
module rect_row_mask
  import rect_loop_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = 2,
  parameter int CW   = 2
) (
  input  logic [RW-1:0]        row,
  input  logic [RW-1:0]        r_lo,
  input  logic [RW-1:0]        r_hi,
  input  logic [CW-1:0]        c_lo,
  input  logic [CW-1:0]        c_hi,
  input  logic                 ends_only,
  output logic [ROWS*COLS-1:0] mask
);

  localparam int N = ROWS * COLS;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic ends;

  // Build the mask bit by bit for the selected row; rows outside [r_lo,r_hi] give zero.
  always_comb begin
    mask = '0;
    ends = 1'b0;
    if (int'(row) >= int'(r_lo) && int'(row) <= int'(r_hi)) begin
      ends = ends_only || (row != r_lo && row != r_hi);
      for (int c = 0; c < COLS; c++) begin
        if (ends ? (c == int'(c_lo) || c == int'(c_hi))
                 : (c >= int'(c_lo) && c <= int'(c_hi)))
          mask = mask | (ONE << bit_idx(int'(row), c, ROWS, COLS));
      end
    end
  end

endmodule

// File: rtl/rect_loop_engine.sv
// Register-held bit matrix with queued rectangle flip commands.
// CORNERS flips the four corners on the accept edge; PERIMETER walks the
// rectangle loop one row per cycle in the SWEEP state.
module rect_loop_engine
  import rect_loop_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int N    = ROWS * COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [N-1:0]     load_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [RW-1:0]    cmd_r1,
  input  logic [RW-1:0]    cmd_r2,
  input  logic [CW-1:0]    cmd_c1,
  input  logic [CW-1:0]    cmd_c2,
  output logic [N-1:0]     m_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] flip_count
);

  state_e          state, state_n;
  mode_e           mode;
  logic            accept, range_bad, sweep_last;
  logic [RW-1:0]   r_lo, r_hi, r_lo_q, r_hi_q, row_ptr;
  logic [CW-1:0]   c_lo, c_hi, c_lo_q, c_hi_q;
  logic [N-1:0]    mask_a, mask_b, corner_mask, row_mask;

  assign mode       = mode_e'(cmd_mode);
  assign cmd_ready  = (state == IDLE) && !load_valid && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign range_bad  = (int'(cmd_r1) >= ROWS) || (int'(cmd_r2) >= ROWS) ||
                      (int'(cmd_c1) >= COLS) || (int'(cmd_c2) >= COLS);
  assign r_lo       = (cmd_r1 < cmd_r2) ? cmd_r1 : cmd_r2;
  assign r_hi       = (cmd_r1 < cmd_r2) ? cmd_r2 : cmd_r1;
  assign c_lo       = (cmd_c1 < cmd_c2) ? cmd_c1 : cmd_c2;
  assign c_hi       = (cmd_c1 < cmd_c2) ? cmd_c2 : cmd_c1;
  assign sweep_last = (row_ptr == r_hi_q);
  assign busy       = (state == SWEEP);

  // Corner rows r1 and r2, each restricted to columns c1/c2; OR merges coincident corners.
  rect_row_mask #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_corner_a (
    .row(cmd_r1), .r_lo('0), .r_hi(RW'(ROWS - 1)), .c_lo(cmd_c1), .c_hi(cmd_c2),
    .ends_only(1'b1), .mask(mask_a)
  );

  rect_row_mask #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_corner_b (
    .row(cmd_r2), .r_lo('0), .r_hi(RW'(ROWS - 1)), .c_lo(cmd_c1), .c_hi(cmd_c2),
    .ends_only(1'b1), .mask(mask_b)
  );

  assign corner_mask = mask_a | mask_b;

  // Loop mask for the row currently being swept, from the latched bounds.
  rect_row_mask #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_sweep (
    .row(row_ptr), .r_lo(r_lo_q), .r_hi(r_hi_q), .c_lo(c_lo_q), .c_hi(c_hi_q),
    .ends_only(1'b0), .mask(row_mask)
  );

  // Next-state logic: only an in-range PERIMETER accept enters SWEEP.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && !range_bad && mode == PERIMETER) state_n = SWEEP;
      SWEEP:   if (sweep_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Latch normalised bounds on accept and advance the row pointer while sweeping.
  always_ff @(posedge clk) begin
    if (accept) begin
      r_lo_q  <= r_lo;
      r_hi_q  <= r_hi;
      c_lo_q  <= c_lo;
      c_hi_q  <= c_hi;
      row_ptr <= r_lo;
    end else if (state == SWEEP) begin
      row_ptr <= row_ptr + RW'(1);
    end
  end

  // Matrix, completion pulses and completed-command counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_out      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      flip_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (load_valid) begin
          m_out <= load_data;
        end else if (accept) begin
          if (range_bad) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (mode == CORNERS) begin
            m_out      <= m_out ^ corner_mask;
            done       <= 1'b1;
            flip_count <= flip_count + CNT_W'(1);
          end
        end
      end else begin
        m_out <= m_out ^ row_mask;
        if (sweep_last) begin
          done       <= 1'b1;
          flip_count <= flip_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_loop_engine.sv
// Directed bench for rect_loop_engine: a 4x4 instance and a 3x5 instance.
module tb_rect_loop_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4x4 instance signals
  logic        lv4 = 1'b0, cv4 = 1'b0, cm4 = 1'b0;
  logic [15:0] ld4 = '0;
  logic [1:0]  r1_4 = '0, r2_4 = '0, c1_4 = '0, c2_4 = '0;
  logic        rdy4, busy4, done4, err4;
  logic [15:0] m4, cnt4;

  // 3x5 instance signals
  logic        lv35 = 1'b0, cv35 = 1'b0, cm35 = 1'b0;
  logic [14:0] ld35 = '0;
  logic [1:0]  r1_35 = '0, r2_35 = '0;
  logic [2:0]  c1_35 = '0, c2_35 = '0;
  logic        rdy35, busy35, done35, err35;
  logic [14:0] m35;
  logic [15:0] cnt35;

  int n_cmp = 0;
  int n_bad = 0;

  rect_loop_engine #(.ROWS(4), .COLS(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
    .cmd_valid(cv4), .cmd_ready(rdy4), .cmd_mode(cm4),
    .cmd_r1(r1_4), .cmd_r2(r2_4), .cmd_c1(c1_4), .cmd_c2(c2_4),
    .m_out(m4), .busy(busy4), .done(done4), .err(err4), .flip_count(cnt4)
  );

  rect_loop_engine #(.ROWS(3), .COLS(5), .CNT_W(16)) dut35 (
    .clk(clk), .rst(rst), .load_valid(lv35), .load_data(ld35),
    .cmd_valid(cv35), .cmd_ready(rdy35), .cmd_mode(cm35),
    .cmd_r1(r1_35), .cmd_r2(r2_35), .cmd_c1(c1_35), .cmd_c2(c2_35),
    .m_out(m35), .busy(busy35), .done(done35), .err(err35), .flip_count(cnt35)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic mode, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d);
    cm4 = mode; r1_4 = a; r2_4 = b; c1_4 = c; c2_4 = d; cv4 = 1'b1;
    tick();
    cv4 = 1'b0;
  endtask

  task automatic load4(input logic [15:0] v);
    lv4 = 1'b1; ld4 = v;
    tick();
    lv4 = 1'b0;
  endtask

  int waited;

  initial begin
    // Reset
    tick(); tick();
    chk("rst_m_out", 32'(m4), 32'h0);
    chk("rst_count", 32'(cnt4), 32'h0);
    chk("rst_busy_done_err", {29'b0, busy4, done4, err4}, 32'h0);
    chk("rst_ready", 32'(rdy4), 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(rdy4), 32'h1);

    // 1: CORNERS full square on zeros
    send4(1'b0, 2'd0, 2'd3, 2'd0, 2'd3);
    chk("t1_m_out", 32'(m4), 32'h9009);
    chk("t1_done_err", {30'b0, done4, err4}, 32'h2);
    chk("t1_count", 32'(cnt4), 32'h1);
    tick();
    chk("t1_done_drop", 32'(done4), 32'h0);

    // 2: PERIMETER full square; a load during SWEEP is ignored
    load4(16'h0000);
    send4(1'b1, 2'd0, 2'd3, 2'd0, 2'd3);
    chk("t2_busy", 32'(busy4), 32'h1);
    chk("t2_ready_low", 32'(rdy4), 32'h0);
    lv4 = 1'b1; ld4 = 16'hFFFF;
    waited = 0;
    while (!done4 && waited < 20) begin
      tick();
      lv4 = 1'b0;
      waited++;
    end
    chk("t2_cycles_to_done", 32'(waited), 32'd4);
    chk("t2_m_out", 32'(m4), 32'hF99F);
    chk("t2_busy_end", 32'(busy4), 32'h0);
    chk("t2_count", 32'(cnt4), 32'h2);

    // 3: coincident corners flip a single bit, twice back-to-back
    load4(16'h0000);
    send4(1'b0, 2'd1, 2'd1, 2'd2, 2'd2);
    chk("t3_first", 32'(m4), 32'h0200);
    send4(1'b0, 2'd1, 2'd1, 2'd2, 2'd2);
    chk("t3_second", 32'(m4), 32'h0000);
    chk("t3_done", 32'(done4), 32'h1);
    chk("t3_count", 32'(cnt4), 32'h4);

    // 4: PERIMETER with reversed indices, two rows
    load4(16'h0000);
    send4(1'b1, 2'd2, 2'd1, 2'd2, 2'd1);
    chk("t4_ready_low", 32'(rdy4), 32'h0);
    tick();
    chk("t4_ready_low2", 32'(rdy4), 32'h0);
    chk("t4_not_done", 32'(done4), 32'h0);
    tick();
    chk("t4_done", 32'(done4), 32'h1);
    chk("t4_m_out", 32'(m4), 32'h0660);
    chk("t4_count", 32'(cnt4), 32'h5);

    // 5: 3x5 range errors and one valid corner command
    lv35 = 1'b1; ld35 = 15'h1234;
    tick();
    lv35 = 1'b0;
    cm35 = 1'b0; r1_35 = 2'd3; r2_35 = 2'd0; c1_35 = 3'd0; c2_35 = 3'd1; cv35 = 1'b1;
    tick();
    cv35 = 1'b0;
    chk("t5_m_out", 32'(m35), 32'h1234);
    chk("t5_done_err", {30'b0, done35, err35}, 32'h3);
    chk("t5_count", 32'(cnt35), 32'h0);
    tick();
    chk("t5_pulse_drop", {30'b0, done35, err35}, 32'h0);
    cm35 = 1'b1; r1_35 = 2'd0; r2_35 = 2'd1; c1_35 = 3'd5; c2_35 = 3'd0; cv35 = 1'b1;
    tick();
    cv35 = 1'b0;
    chk("t5_col_err", {30'b0, done35, err35}, 32'h3);
    chk("t5_col_busy", 32'(busy35), 32'h0);
    cm35 = 1'b0; r1_35 = 2'd0; r2_35 = 2'd2; c1_35 = 3'd0; c2_35 = 3'd4; cv35 = 1'b1;
    tick();
    cv35 = 1'b0;
    chk("t5_corner_m_out", 32'(m35), 32'h5625);
    chk("t5_corner_count", 32'(cnt35), 32'h1);

    // 6a: load wins over a simultaneous command
    lv4 = 1'b1; ld4 = 16'hA5A5;
    cm4 = 1'b0; r1_4 = 2'd0; r2_4 = 2'd3; c1_4 = 2'd0; c2_4 = 2'd3; cv4 = 1'b1;
    #1;
    chk("t6_ready_load", 32'(rdy4), 32'h0);
    tick();
    lv4 = 1'b0; cv4 = 1'b0;
    chk("t6_load_m_out", 32'(m4), 32'hA5A5);
    chk("t6_load_no_done", 32'(done4), 32'h0);
    chk("t6_load_count", 32'(cnt4), 32'h5);

    // 6b: reset in the middle of a sweep
    send4(1'b1, 2'd0, 2'd3, 2'd0, 2'd3);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t6_abort_m_out", 32'(m4), 32'h0);
    chk("t6_abort_busy", 32'(busy4), 32'h0);
    chk("t6_abort_count", 32'(cnt4), 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_ready_after", 32'(rdy4), 32'h1);
    tick();
    chk("t6_no_done", 32'(done4), 32'h0);
    chk("t6_m_out_held", 32'(m4), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
